// File: rtl/fsm_sendharq_nbuf.sv
// Multi-buffer HARQ send engine: arbitrates combine buffers round-robin,
// streams each buffer from SRAM through a 2-entry skid stage, quantises the
// LLRs and tracks a per-user code-block counter.
module fsm_sendharq_nbuf #(
  parameter int NBUF      = 2,
  parameter int NUSER     = 8,
  parameter int LANES     = 16,
  parameter int LLR_IN_W  = 10,
  parameter int LLR_OUT_W = 6,
  parameter int ADDR_W    = 11,
  parameter int SAT_MODE  = 0
) (
  input  logic                              i_core_clk,
  input  logic                              i_rx_rstn,
  input  logic                              i_rdm_slot_start,
  input  logic [NBUF-1:0]                   i_req,
  input  logic [NBUF*16-1:0]                i_add_amount,
  input  logic [NBUF*4-1:0]                 i_user_index,
  output logic [ADDR_W-1:0]                 o_rd_addr,
  output logic [$clog2(NBUF)-1:0]           o_rd_sel,
  input  logic [NBUF*LANES*LLR_IN_W-1:0]    i_rd_data,
  output logic [NBUF-1:0]                   o_busy,
  output logic [NBUF-1:0]                   o_comp,
  output logic [LANES*LLR_OUT_W-1:0]        o_data,
  output logic                              o_valid,
  input  logic                              i_ready,
  output logic [3:0]                        o_amount,
  output logic                              o_last,
  output logic [3:0]                        o_user_index,
  output logic [7:0]                        o_cb_index
);

  localparam int SEL_W  = $clog2(NBUF);
  localparam int WORD_W = LANES * LLR_OUT_W;
  localparam int IN_WW  = LANES * LLR_IN_W;
  localparam int SH     = LLR_IN_W - LLR_OUT_W;
  localparam logic signed [LLR_IN_W:0] HALF_C = (LLR_IN_W+1)'(1 << (SH - 1));
  localparam logic signed [LLR_IN_W:0] MAX_C  = (LLR_IN_W+1)'((1 << (LLR_OUT_W - 1)) - 1);
  localparam logic signed [LLR_IN_W:0] MIN_C  = ~MAX_C;

  typedef enum logic [2:0] {IDLE, ARB, SEND, DRAIN, COMP, ADJ} state_e;

  state_e               state_q, state_d;
  logic [SEL_W-1:0]     rr_q, gnt_q, grant;
  logic [ADDR_W-1:0]    addr_q, last_addr_q;
  logic [3:0]           amt_q, user_q;
  logic [7:0]           cb_q, cb_lookup;
  logic [NBUF-1:0]      busy_q, comp_q, req_rot;
  logic                 rd_vld_q, rd_last_q;
  logic [WORD_W-1:0]    sk_data_q [2];
  logic [1:0]           sk_last_q;
  logic                 sk_rd_q, sk_wr_q;
  logic [1:0]           sk_cnt_q;
  logic [7:0]           cnt_q [NUSER];
  logic [15:0]          add_sel;
  logic [3:0]           usr_sel;
  logic [IN_WW-1:0]     rd_word;
  logic [WORD_W-1:0]    q_word;
  logic                 pop, issue, found;
  int                   gi;

  // Quantise one LLR: truncate, or round-half-up then clamp to the output range.
  function automatic logic signed [LLR_OUT_W-1:0] quant(input logic signed [LLR_IN_W-1:0] x);
    logic signed [LLR_IN_W:0] s;
    if (SAT_MODE == 0) return x[LLR_IN_W-1 -: LLR_OUT_W];
    s = (LLR_IN_W+1)'(x) + HALF_C;
    s = s >>> SH;
    if (s > MAX_C) return MAX_C[LLR_OUT_W-1:0];
    if (s < MIN_C) return MIN_C[LLR_OUT_W-1:0];
    return s[LLR_OUT_W-1:0];
  endfunction

  // Round-robin pick: rotate requests so the search starts after the last served buffer.
  always_comb begin
    req_rot = NBUF'({i_req, i_req} >> rr_q);
    grant   = rr_q;
    found   = 1'b0;
    gi      = 0;
    for (int k = 0; k < NBUF; k++) begin
      if (!found && req_rot[k]) begin
        gi    = int'(rr_q) + k;
        if (gi >= NBUF) gi = gi - NBUF;
        grant = SEL_W'(gi);
        found = 1'b1;
      end
    end
  end

  // Select the granted buffer's descriptor, its user's counter and its read data.
  always_comb begin
    add_sel   = '0;
    usr_sel   = '0;
    rd_word   = '0;
    cb_lookup = '0;
    for (int b = 0; b < NBUF; b++) begin
      if (grant == SEL_W'(b)) begin
        add_sel = i_add_amount[b*16 +: 16];
        usr_sel = i_user_index[b*4 +: 4];
      end
      if (gnt_q == SEL_W'(b)) rd_word = i_rd_data[b*IN_WW +: IN_WW];
    end
    for (int u = 0; u < NUSER; u++) begin
      if (usr_sel == 4'(u)) cb_lookup = cnt_q[u];
    end
    for (int l = 0; l < LANES; l++) begin
      q_word[l*LLR_OUT_W +: LLR_OUT_W] = quant(rd_word[l*LLR_IN_W +: LLR_IN_W]);
    end
  end

  // Issue a read only if the word it returns is guaranteed a skid slot; a word
  // leaving this cycle frees its slot so back-to-back issue holds at full rate.
  always_comb begin
    pop   = (sk_cnt_q != 2'd0) && i_ready;
    issue = (state_q == SEND) &&
            ((sk_cnt_q - {1'b0, pop} + {1'b0, rd_vld_q}) < 2'd2);
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|i_req) state_d = ARB;
      ARB:     state_d = SEND;
      SEND:    if (issue && (addr_q == last_addr_q)) state_d = DRAIN;
      DRAIN:   if ((sk_cnt_q == 2'd0) && !rd_vld_q) state_d = COMP;
      COMP:    state_d = ADJ;
      ADJ:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
    if (!i_rx_rstn) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // Transfer context, address generation, read tracking and skid stage.
  always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
    if (!i_rx_rstn) begin
      rr_q        <= '0;
      gnt_q       <= '0;
      addr_q      <= '0;
      last_addr_q <= '0;
      amt_q       <= '0;
      user_q      <= '0;
      cb_q        <= '0;
      busy_q      <= '0;
      comp_q      <= '0;
      rd_vld_q    <= 1'b0;
      rd_last_q   <= 1'b0;
      sk_data_q[0] <= '0;
      sk_data_q[1] <= '0;
      sk_last_q   <= '0;
      sk_rd_q     <= 1'b0;
      sk_wr_q     <= 1'b0;
      sk_cnt_q    <= '0;
    end else begin
      comp_q <= '0;
      if (state_q == ARB) begin
        gnt_q       <= grant;
        rr_q        <= (grant == SEL_W'(NBUF - 1)) ? '0 : grant + 1'b1;
        addr_q      <= '0;
        last_addr_q <= ADDR_W'(add_sel[15:4]);
        amt_q       <= add_sel[3:0];
        user_q      <= usr_sel;
        cb_q        <= cb_lookup;
        busy_q      <= NBUF'(1) << grant;
      end
      if (state_q == COMP) busy_q <= '0;
      if ((state_q == DRAIN) && (state_d == COMP)) comp_q <= NBUF'(1) << gnt_q;
      if (issue && (addr_q != last_addr_q)) addr_q <= addr_q + 1'b1;
      rd_vld_q  <= issue;
      rd_last_q <= issue && (addr_q == last_addr_q);
      if (rd_vld_q) begin
        sk_data_q[sk_wr_q] <= q_word;
        sk_last_q[sk_wr_q] <= rd_last_q;
        sk_wr_q            <= ~sk_wr_q;
      end
      if (pop) sk_rd_q <= ~sk_rd_q;
      sk_cnt_q <= sk_cnt_q + {1'b0, rd_vld_q} - {1'b0, pop};
    end
  end

  // Per-user code-block counters; a slot clear overrides the completion increment.
  always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
    if (!i_rx_rstn) begin
      for (int u = 0; u < NUSER; u++) cnt_q[u] <= '0;
    end else if (i_rdm_slot_start) begin
      for (int u = 0; u < NUSER; u++) cnt_q[u] <= '0;
    end else if (state_q == COMP) begin
      for (int u = 0; u < NUSER; u++) begin
        if (user_q == 4'(u)) cnt_q[u] <= cnt_q[u] + 8'd1;
      end
    end
  end

  assign o_rd_addr    = addr_q;
  assign o_rd_sel     = gnt_q;
  assign o_busy       = busy_q;
  assign o_comp       = comp_q;
  assign o_valid      = (sk_cnt_q != 2'd0);
  assign o_data       = sk_data_q[sk_rd_q];
  assign o_last       = o_valid && sk_last_q[sk_rd_q];
  assign o_amount     = !o_valid ? 4'h0 : (o_last ? amt_q : 4'hF);
  assign o_user_index = user_q;
  assign o_cb_index   = cb_q;

endmodule

// File: tb/tb_fsm_sendharq_nbuf.sv
// Scoreboard bench for fsm_sendharq_nbuf (NBUF=4, rounding quantiser).
module tb_fsm_sendharq_nbuf;

  localparam int NB = 4;
  localparam int LN = 16;
  localparam int IW = 10;
  localparam int OW = 6;
  localparam int DW = LN * OW;
  localparam int NU = 8;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [3:0]    amt;
    logic          last;
    logic [3:0]    user;
    logic [7:0]    cb;
  } exp_t;

  logic              clk = 1'b0;
  logic              rstn;
  logic              slot;
  logic [NB-1:0]     req;
  logic [NB*16-1:0]  add_amount;
  logic [NB*4-1:0]   user_index;
  logic [10:0]       rd_addr;
  logic [1:0]        rd_sel;
  logic [NB*LN*IW-1:0] rd_data;
  logic [NB-1:0]     busy, comp;
  logic [DW-1:0]     data;
  logic              valid, ready;
  logic [3:0]        amount, uidx;
  logic              last;
  logic [7:0]        cbidx;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  int   cb_model[16];
  bit   rdy_toggle = 1'b0;
  // Hand-computed quantiser pairs for SAT_MODE=1 (in -> out).
  int   in_tbl[8]  = '{511, -512, 23, 24, -24, -25, 100, -9};
  int   out_tbl[8] = '{31,  -32,  1,  2,  -1,  -2,  6,   -1};
  int   rr_order[5] = '{0, 1, 2, 3, 0};

  fsm_sendharq_nbuf #(
    .NBUF(NB), .NUSER(NU), .LANES(LN), .LLR_IN_W(IW), .LLR_OUT_W(OW),
    .ADDR_W(11), .SAT_MODE(1)
  ) dut (
    .i_core_clk(clk), .i_rx_rstn(rstn), .i_rdm_slot_start(slot),
    .i_req(req), .i_add_amount(add_amount), .i_user_index(user_index),
    .o_rd_addr(rd_addr), .o_rd_sel(rd_sel), .i_rd_data(rd_data),
    .o_busy(busy), .o_comp(comp), .o_data(data), .o_valid(valid),
    .i_ready(ready), .o_amount(amount), .o_last(last),
    .o_user_index(uidx), .o_cb_index(cbidx)
  );

  always #5 clk = ~clk;

  // SRAM model: every buffer returns a pattern keyed by (buffer, address, lane).
  always @(posedge clk) begin
    for (int b = 0; b < NB; b++)
      for (int l = 0; l < LN; l++)
        rd_data[(b*LN + l)*IW +: IW] <= 10'(in_tbl[(b*3 + int'(rd_addr) + l) % 8]);
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_word(input int b, input int a);
    logic [DW-1:0] w;
    w = '0;
    for (int l = 0; l < LN; l++) w[l*OW +: OW] = 6'(out_tbl[(b*3 + a + l) % 8]);
    return w;
  endfunction

  task automatic push_words(input int b, input logic [15:0] amt, input logic [3:0] user);
    int   n;
    exp_t e;
    n = int'(amt[15:4]) + 1;
    for (int i = 0; i < n; i++) begin
      e.data = exp_word(b, i);
      e.amt  = (i == n-1) ? amt[3:0] : 4'hF;
      e.last = (i == n-1);
      e.user = user;
      e.cb   = (user < NU) ? 8'(cb_model[user]) : 8'd0;
      q.push_back(e);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_data"}, data, 0);
    chk({tag, "_rd_addr"}, rd_addr, 0);
    chk({tag, "_rd_sel"}, rd_sel, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_comp"}, comp, 0);
    chk({tag, "_last"}, last, 0);
    chk({tag, "_amount"}, amount, 0);
    chk({tag, "_user"}, uidx, 0);
    chk({tag, "_cb"}, cbidx, 0);
  endtask

  task automatic run_xfer(input int b, input logic [15:0] amt, input logic [3:0] user,
                          input bit toggle, input bit clr_at_comp);
    int lat, ncomp, t;
    push_words(b, amt, user);
    add_amount[b*16 +: 16] = amt;
    user_index[b*4 +: 4]   = user;
    rdy_toggle = toggle;
    req[b] = 1'b1;
    t = 0;
    while (!busy[b] && t < 50) begin @(negedge clk); t++; end
    chk("busy_timeout", busy[b], 1);
    req[b] = 1'b0;
    add_amount[b*16 +: 16] = 16'hFFFF;
    user_index[b*4 +: 4]   = 4'hE;
    lat = 0;
    while (!valid && lat < 20) begin @(negedge clk); lat++; end
    chk("first_valid_latency", lat, 2);
    ncomp = 0;
    t = 0;
    while (busy[b] && t < 300) begin
      if (comp[b]) begin
        ncomp++;
        if (clr_at_comp) begin
          slot = 1'b1;
          @(posedge clk); #1;
          slot = 1'b0;
        end
      end
      @(negedge clk);
      t++;
    end
    chk("comp_pulses", ncomp, 1);
    chk("words_left", q.size(), 0);
    rdy_toggle = 1'b0;
    if (clr_at_comp) for (int u = 0; u < 16; u++) cb_model[u] = 0;
    else if (user < NU) cb_model[user] = (cb_model[user] + 1) % 256;
    repeat (2) @(negedge clk);
  endtask

  // i_ready driver: held high or toggling every cycle.
  initial begin
    ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      ready = rdy_toggle ? ~ready : 1'b1;
    end
  end

  // Monitor: every presented word must equal the scoreboard head; pop on acceptance.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rstn && valid) begin
        if (q.size() == 0) begin
          chk("unexpected_word", data, 0);
          chk("unexpected_word_valid", valid, 0);
        end else begin
          e = q[0];
          chk("word_data", data, e.data);
          chk("word_amount", amount, e.amt);
          chk("word_last", last, e.last);
          chk("word_user", uidx, e.user);
          chk("word_cb", cbidx, e.cb);
          if (ready) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, idx;
    for (int u = 0; u < 16; u++) cb_model[u] = 0;
    rstn = 1'b0; slot = 1'b0; req = '0; add_amount = '0; user_index = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // Single buffer, full rate, then the same with backpressure (CB 0 -> 1).
    run_xfer(0, 16'h0035, 4'd2, 1'b0, 1'b0);
    run_xfer(0, 16'h0035, 4'd2, 1'b1, 1'b0);
    // Slot clear coinciding with COMP of user 3, then confirm its counter is 0.
    run_xfer(1, 16'h0012, 4'd3, 1'b0, 1'b1);
    run_xfer(1, 16'h0000, 4'd3, 1'b1, 1'b0);
    // User index beyond NUSER: CB index stays 0.
    run_xfer(2, 16'h001F, 4'd9, 1'b0, 1'b0);
    run_xfer(2, 16'h001F, 4'd9, 1'b0, 1'b0);

    // Reset during the second word of a transfer.
    push_words(3, 16'h0035, 4'd1);
    add_amount[3*16 +: 16] = 16'h0035;
    user_index[3*4 +: 4]   = 4'd1;
    req[3] = 1'b1;
    t = 0;
    while (!valid && t < 50) begin @(negedge clk); t++; end
    chk("midreset_first_valid", valid, 1);
    @(posedge clk); #1;
    rstn = 1'b0;
    req  = '0;
    #1;
    check_zero("midreset");
    q.delete();
    for (int u = 0; u < 16; u++) cb_model[u] = 0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    // Round-robin with all four buffers requesting: 0,1,2,3,0, starting at address 0.
    add_amount = {16'h001A, 16'h0007, 16'h0010, 16'h0003};
    user_index = {4'd7, 4'd6, 4'd5, 4'd4};
    push_words(0, 16'h0003, 4'd4);
    cb_model[4] = 1;
    push_words(1, 16'h0010, 4'd5);
    push_words(2, 16'h0007, 4'd6);
    push_words(3, 16'h001A, 4'd7);
    push_words(0, 16'h0003, 4'd4);
    req = 4'hF;
    for (int k = 0; k < 5; k++) begin
      t = 0;
      while (busy == '0 && t < 100) begin @(negedge clk); t++; end
      idx = -1;
      for (int b = 0; b < NB; b++) if (busy[b]) idx = b;
      chk("rr_grant", idx, rr_order[k]);
      if (k == 4) req = '0;
      t = 0;
      while (busy != '0 && t < 100) begin @(negedge clk); t++; end
    end
    repeat (4) @(negedge clk);
    chk("rr_words_left", q.size(), 0);
    chk("rr_idle_valid", valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
